// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : irq_ctrl_pkg                                                |
// | Desc   : Register map, CTRL bit positions and FSM encoding for the   |
// |          programmable interrupt controller.                          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package irq_ctrl_pkg;

    localparam logic [2:0] C_REG_CTRL = 3'd0;
    localparam logic [2:0] C_REG_MASK = 3'd1;
    localparam logic [2:0] C_REG_PEND = 3'd2;
    localparam logic [2:0] C_REG_MODE = 3'd3;
    localparam logic [2:0] C_REG_VEC  = 3'd4;
    localparam logic [2:0] C_REG_RAW  = 3'd5;

    localparam int C_CTRL_GIE  = 0;
    localparam int C_CTRL_AEOI = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_SERVICE = 2'b10
    } irq_state_e;

endpackage
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : irq_prio_enc                                                |
// | Desc   : Combinational lowest-index-wins priority encoder.           |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int N = 6,
    parameter int W = 4
) (
    input  logic [N-1:0] req_i,
    output logic         valid_o,
    output logic [W-1:0] id_o
);

    // Scanning downward lets the lowest set index overwrite any higher one.
    always_comb begin
        valid_o = |req_i;
        id_o    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                id_o = W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : irq_ctrl                                                    |
// | Desc   : Bus-mapped interrupt controller: edge/level latching, mask, |
// |          fixed priority, single registered request with source ID.   |
// |          Define IRQC_SYNC_EN to insert a 2-flop src synchronizer.    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 6,
    parameter int ID_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      Addr,
    input  logic             WE,
    input  logic [31:0]      Din,
    output logic [31:0]      Dout,
    input  logic [N_SRC-1:0] src,
    input  logic             int_ack,
    output logic             irq,
    output logic [ID_W-1:0]  irq_id
);

    logic [1:0]       ctrl_q;
    logic [N_SRC-1:0] mask_q;
    logic [N_SRC-1:0] mode_q;
    logic [N_SRC-1:0] pend_q;
    logic [N_SRC-1:0] pend_d;
    logic [N_SRC-1:0] s_sync;
    logic [N_SRC-1:0] s_prev_q;
    irq_state_e       state_q;
    logic             irq_q;
    logic [ID_W-1:0]  irq_id_q;

    logic [2:0]       w_word;
    logic [N_SRC-1:0] w_set;
    logic [N_SRC-1:0] w_active;
    logic [N_SRC-1:0] w_id_onehot;
    logic [N_SRC-1:0] w_w1c;
    logic [N_SRC-1:0] w_ack_clr;
    logic             w_req;
    logic             w_any;
    logic [ID_W-1:0]  w_win_id;
    logic             w_vec_wr;
    logic             w_unused_bits;

    assign w_word        = Addr[4:2];
    assign w_vec_wr      = WE && (w_word == C_REG_VEC);
    assign w_unused_bits = ^{Addr[31:5], Addr[1:0], Din};

`ifdef IRQC_SYNC_EN
    logic [N_SRC-1:0] sync1_q;
    logic [N_SRC-1:0] sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= src;
            sync2_q <= sync1_q;
        end
    end

    assign s_sync = sync2_q;
`else
    assign s_sync = src;
`endif

    assign w_set    = (mode_q & s_sync & ~s_prev_q) | (~mode_q & s_sync);
    assign w_active = pend_q & mask_q;
    assign w_req    = ctrl_q[C_CTRL_GIE] & w_any;

    irq_prio_enc #(
        .N (N_SRC),
        .W (ID_W)
    ) u_prio (
        .req_i   (w_active),
        .valid_o (w_any),
        .id_o    (w_win_id)
    );

    always_comb begin
        w_id_onehot = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_id_onehot[i] = (irq_id_q == ID_W'(i));
        end
    end

    // Clears from W1C and acknowledge are applied first so a same-cycle set wins.
    always_comb begin
        w_w1c     = (WE && (w_word == C_REG_PEND)) ? Din[N_SRC-1:0] : '0;
        w_ack_clr = ((state_q == ST_REQ) && int_ack) ? (w_id_onehot & mode_q) : '0;
        pend_d    = (pend_q & ~(w_w1c | w_ack_clr)) | w_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q   <= '0;
            mask_q   <= '0;
            mode_q   <= '0;
            pend_q   <= '0;
            s_prev_q <= '0;
        end else begin
            s_prev_q <= s_sync;
            pend_q   <= pend_d;
            if (WE && (w_word == C_REG_CTRL)) ctrl_q <= Din[1:0];
            if (WE && (w_word == C_REG_MASK)) mask_q <= Din[N_SRC-1:0];
            if (WE && (w_word == C_REG_MODE)) mode_q <= Din[N_SRC-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            irq_q    <= 1'b0;
            irq_id_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_req) begin
                        state_q  <= ST_REQ;
                        irq_q    <= 1'b1;
                        irq_id_q <= w_win_id;
                    end
                end
                ST_REQ: begin
                    if (int_ack) begin
                        state_q <= ctrl_q[C_CTRL_AEOI] ? ST_IDLE : ST_SERVICE;
                        irq_q   <= 1'b0;
                    end else if (!w_req) begin
                        state_q <= ST_IDLE;
                        irq_q   <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (w_vec_wr) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        case (w_word)
            C_REG_CTRL: Dout = {30'b0, ctrl_q};
            C_REG_MASK: Dout = {{(32-N_SRC){1'b0}}, mask_q};
            C_REG_PEND: Dout = {{(32-N_SRC){1'b0}}, pend_q};
            C_REG_MODE: Dout = {{(32-N_SRC){1'b0}}, mode_q};
            C_REG_VEC:  Dout = {(state_q == ST_SERVICE), {(31-ID_W){1'b0}}, irq_id_q};
            C_REG_RAW:  Dout = {{(32-N_SRC){1'b0}}, s_sync};
            default:    Dout = 32'b0;
        endcase
    end

    assign irq    = irq_q;
    assign irq_id = irq_id_q;

endmodule
`default_nettype wire
